// File: rtl/mem_dbus.sv
// mem_dbus: MIPS MEM stage, load/store over a split req/addr_ok/data_ok bus.
// Holds the pipeline via stallreq until the transaction completes; non-memory ops pass through.
module mem_dbus (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pipe_adv,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state, state_n;
    logic        kill, kill_n;
    logic [31:0] rdata_q, rdata_n;
    logic        is_load, is_store, is_mem, misalign, go;
    logic [1:0]  size;
    logic [31:0] st_data, lane_b, lane_h, ld_data;
    assign is_load  = mem_op_i >= 4'd1 && mem_op_i <= 4'd5;
    assign is_store = mem_op_i >= 4'd6 && mem_op_i <= 4'd8;
    assign is_mem   = is_load || is_store;
    assign size     = (mem_op_i == 4'd1 || mem_op_i == 4'd2 || mem_op_i == 4'd6) ? 2'd0 :
                      (mem_op_i == 4'd3 || mem_op_i == 4'd4 || mem_op_i == 4'd7) ? 2'd1 : 2'd2;
    assign misalign = is_mem && ((size == 2'd1 && mem_addr_i[0]) ||
                                 (size == 2'd2 && mem_addr_i[1:0] != 2'b00));
    assign go       = is_mem && !misalign;
    assign st_data  = size == 2'd0 ? {4{reg2_i[7:0]}} :
                      size == 2'd1 ? {2{reg2_i[15:0]}} : reg2_i;
    assign lane_b   = rdata_q >> {mem_addr_i[1:0], 3'b000};
    assign lane_h   = rdata_q >> {mem_addr_i[1], 4'b0000};
    assign ld_data  = mem_op_i == 4'd1 ? {{24{lane_b[7]}}, lane_b[7:0]} :
                      mem_op_i == 4'd2 ? {24'd0, lane_b[7:0]} :
                      mem_op_i == 4'd3 ? {{16{lane_h[15]}}, lane_h[15:0]} :
                      mem_op_i == 4'd4 ? {16'd0, lane_h[15:0]} : rdata_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            kill    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            kill    <= kill_n;
            rdata_q <= rdata_n;
        end
    end
    // A flush after the request is accepted cannot cancel it; kill drops the result once it drains.
    always_comb begin
        state_n = state;
        kill_n  = kill;
        rdata_n = rdata_q;
        case (state)
            IDLE: state_n = (go && !flush) ? REQ : IDLE;
            REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        rdata_n = data_rdata;
                        state_n = flush ? IDLE : DONE;
                    end else begin
                        state_n = WAIT;
                        kill_n  = flush;
                    end
                end else if (flush) state_n = IDLE;
            end
            WAIT: begin
                if (data_data_ok) begin
                    rdata_n = data_rdata;
                    state_n = (kill || flush) ? IDLE : DONE;
                    kill_n  = 1'b0;
                end else if (flush) kill_n = 1'b1;
            end
            DONE: state_n = (pipe_adv || flush) ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    assign data_req   = !rst && state == REQ;
    assign data_wr    = data_req && is_store;
    assign data_size  = data_req ? size : 2'd0;
    assign data_addr  = data_req ? mem_addr_i : '0;
    assign data_wdata = data_req ? st_data : '0;
    assign stallreq   = !rst && ((state == IDLE && go && !flush) || state == REQ || state == WAIT);
    assign wd_o       = rst ? '0 : wd_i;
    assign wreg_o     = !rst && !misalign && wreg_i && (!is_mem || state == DONE);
    assign wdata_o    = rst ? '0 : (is_load && state == DONE) ? ld_data : wdata_i;
    assign adel_o     = !rst && misalign && is_load;
    assign ades_o     = !rst && misalign && is_store;
    assign badvaddr_o = rst ? '0 : mem_addr_i;
endmodule

// File: tb/tb_mem_dbus.sv
// tb_mem_dbus: randomized load/store transactions against a transaction-level model,
// plus directed misalignment, flush and reset scenarios.
module tb_mem_dbus;
    logic        clk = 0, rst = 1, flush = 0, pipe_adv = 0;
    logic [4:0]  wd_i = 0;
    logic        wreg_i = 0;
    logic [31:0] wdata_i = 0, mem_addr_i = 0, reg2_i = 0, data_rdata = 0;
    logic [3:0]  mem_op_i = 0;
    logic        data_addr_ok = 0, data_data_ok = 0;
    logic        data_req, data_wr, wreg_o, stallreq, adel_o, ades_o;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, wdata_o, badvaddr_o;
    logic [4:0]  wd_o;
    int checks = 0, failures = 0;

    mem_dbus dut (
        .clk(clk), .rst(rst), .flush(flush), .pipe_adv(pipe_adv),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_op_i(mem_op_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
        .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        return (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        int b, h;
        b = (rd / (32'd1 << (8 * a[1:0]))) % 256;
        h = (rd / (32'd1 << (16 * a[1]))) % 65536;
        case (op)
            1: return b >= 128 ? b - 256 : b;
            2: return b;
            3: return h >= 32768 ? h - 65536 : h;
            4: return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [3:0] op, input logic [31:0] r2);
        return op == 6 ? (r2 % 256) * 32'h0101_0101 :
               op == 7 ? (r2 % 65536) * 32'h0001_0001 : r2;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One aligned transaction: slave accepts after a cycles in REQ, returns data d cycles after accept.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r2,
                          input logic [31:0] rd, input int a, input int d);
        int stalls = 0, rq = 0, acc = -1;
        bit done = 0, bus_seen = 0, ld;
        logic [31:0] exp;
        ld = op <= 5;
        @(negedge clk);
        mem_op_i = op; mem_addr_i = addr; reg2_i = r2; wreg_i = ld;
        wd_i = 5'($urandom); wdata_i = $urandom; flush = 0; pipe_adv = 0;
        #1;
        for (int c = 0; c < 40 && !done; c++) begin
            data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
            if (!stallreq) done = 1;
            else begin
                stalls++;
                if (data_req) begin
                    if (!bus_seen) begin
                        bus_seen = 1;
                        check("bus_wr", data_wr, !ld);
                        check("bus_size", data_size, nbytes(op) == 1 ? 0 : nbytes(op) == 2 ? 1 : 2);
                        check("bus_addr", data_addr, addr);
                        if (!ld) check("bus_wdata", data_wdata, model_store(op, r2));
                    end
                    if (rq == a) begin
                        data_addr_ok = 1; acc = 0;
                        if (d == 0) begin data_data_ok = 1; data_rdata = rd; end
                    end
                    rq++;
                end else if (acc >= 0) begin
                    acc++;
                    if (acc == d) begin data_data_ok = 1; data_rdata = rd; end
                end
                step();
            end
        end
        data_addr_ok = 0; data_data_ok = 0;
        check("done_reached", done, 1);
        if (!done) return;
        exp = ld ? model_load(op, addr, rd) : wdata_i;
        check("stall_cycles", stalls, 2 + a + d);
        check("done_wreg", wreg_o, ld);
        check("done_wdata", wdata_o, exp);
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_wdata", wdata_o, exp);
            check("hold_stall", stallreq, 0);
        end
        pipe_adv = 1;
        step();
        pipe_adv = 0; mem_op_i = 0;
    endtask

    task automatic misaligned(input logic [3:0] op, input logic [31:0] addr);
        @(negedge clk);
        mem_op_i = op; mem_addr_i = addr; wreg_i = op <= 5; flush = 0;
        #1;
        check("mis_adel", adel_o, op <= 5);
        check("mis_ades", ades_o, op >= 6);
        check("mis_badv", badvaddr_o, addr);
        check("mis_stall", stallreq, 0);
        check("mis_wreg", wreg_o, 0);
        check("mis_req", data_req, 0);
        step();
        check("mis_req2", data_req, 0);
        mem_op_i = 0;
    endtask

    initial begin
        logic [3:0] op;
        logic [31:0] ad;
        rst = 1; mem_op_i = 5; mem_addr_i = 32'h100; wreg_i = 1; wd_i = 3; wdata_i = 32'hDEAD;
        step(); step();
        check("rst_ctrl", {data_req, stallreq, wreg_o, adel_o, ades_o}, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_badv", badvaddr_o, 0);
        check("rst_wd", wd_o, 0);
        rst = 0; mem_op_i = 0;

        run_op(5, 32'h100, 0, 32'h8081_8283, 0, 1);
        run_op(1, 32'h101, 0, 32'h0000_F000, 0, 1);
        run_op(2, 32'h101, 0, 32'h0000_F000, 1, 2);
        run_op(4, 32'h102, 0, 32'hABCD_0000, 0, 0);
        run_op(3, 32'h102, 0, 32'hABCD_0000, 2, 3);
        run_op(6, 32'h203, 32'h1234_5678, 0, 0, 1);
        run_op(7, 32'h206, 32'h1234_5678, 0, 1, 1);
        run_op(8, 32'h208, 32'h1234_5678, 0, 0, 2);
        misaligned(3, 32'h301);
        misaligned(8, 32'h302);
        misaligned(5, 32'h303);
        misaligned(7, 32'h305);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(1, 8));
            ad = $urandom & ~(32'(nbytes(op)) - 1);
            run_op(op, ad, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_op_i = i[0] ? 4'd0 : 4'd12; wd_i = 5'($urandom); wreg_i = 1'($urandom);
            wdata_i = $urandom;
            #1;
            check("pass_wd", wd_o, wd_i);
            check("pass_wreg", wreg_o, wreg_i);
            check("pass_wdata", wdata_o, wdata_i);
            check("pass_stall", stallreq, 0);
        end

        // Flush in REQ before addr_ok: the request is withdrawn.
        @(negedge clk);
        mem_op_i = 5; mem_addr_i = 32'h400; wreg_i = 1; #1;
        step();
        check("freq_req", data_req, 1);
        flush = 1;
        step();
        flush = 0; #1;
        check("freq_drop", data_req, 0);
        check("freq_idle", stallreq, 1);
        mem_op_i = 0;

        // Flush in WAIT: the outstanding read drains and is discarded.
        @(negedge clk);
        mem_op_i = 5; mem_addr_i = 32'h500; wreg_i = 1; #1;
        step();
        data_addr_ok = 1;
        step();
        data_addr_ok = 0; flush = 1;
        check("fwait_noreq", data_req, 0);
        step();
        flush = 0; mem_op_i = 0; wreg_i = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fwait_wreg", wreg_o, 0);
            check("fwait_stall", stallreq, 1);
            check("fwait_req", data_req, 0);
            step();
        end
        data_data_ok = 1; data_rdata = 32'h1111_2222;
        step();
        data_data_ok = 0; mem_op_i = 5; wreg_i = 1; #1;
        check("fwait_idle", stallreq, 1);
        check("fwait_wreg2", wreg_o, 0);
        mem_op_i = 0;

        // Reset while a read is outstanding.
        @(negedge clk);
        mem_op_i = 5; mem_addr_i = 32'h600; wreg_i = 1; #1;
        step();
        data_addr_ok = 1;
        step();
        data_addr_ok = 0; rst = 1; #1;
        check("rstw_ctrl", {data_req, stallreq, wreg_o, adel_o, ades_o}, 0);
        check("rstw_badv", badvaddr_o, 0);
        check("rstw_wdata", wdata_o, 0);
        step();
        rst = 0; #1;
        check("rstw_idle", stallreq, 1);
        check("rstw_req", data_req, 0);
        mem_op_i = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
